// File: rtl/spram_pkg.sv
// Shared types and default parameters for the single-port SRAM initiator.
package spram_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_SIZE      = 2048;
  localparam int DEF_MAX_LEN   = 16;
  localparam int DEF_RSP_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } spram_init_state_t;

endpackage

// File: rtl/spram_rsp_fifo.sv
// First-word fall-through response FIFO holding {last, data} for returned read beats.
module spram_rsp_fifo #(
  parameter  int DW    = 33,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;
  // Head is forced to zero when empty so the response port reads 0 out of reset.
  assign head   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The initiator's credit check must make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_ok && (count == CW'(DEPTH))));

endmodule

// File: rtl/spram_initiator.sv
// Burst command front-end for a one-cycle SRAM: registered strobes, credit-limited reads.
module spram_initiator
  import spram_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int SIZE      = DEF_SIZE,
  parameter  int MAX_LEN   = DEF_MAX_LEN,
  parameter  int RSP_DEPTH = DEF_RSP_DEPTH,
  localparam int AW        = $clog2(SIZE),
  localparam int LW        = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LW-1:0]    cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             sram_wen,
  output logic             sram_ren,
  output logic [AW-1:0]    sram_waddr,
  output logic [AW-1:0]    sram_raddr,
  output logic [WIDTH-1:0] sram_wdata,
  input  logic [WIDTH-1:0] sram_rdata,
  input  logic             sram_ready
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int UW = CW + 1;

  spram_init_state_t state_q, state_d;
  logic [AW-1:0]  addr_q;
  logic [LW-1:0]  beats_q;
  logic [1:0]     outstanding_q;
  logic [3:0]     tag_q;
  logic [1:0]     tag_idx;
  logic [CW-1:0]  fifo_count;
  logic [WIDTH:0] fifo_head;
  logic [UW-1:0]  credits_used;
  logic           accept, wr_beat, issue, ret, last_beat;

  assign last_beat    = (beats_q == '0);
  assign ret          = sram_ready && (outstanding_q != 2'd0);
  assign credits_used = UW'(outstanding_q) + UW'(fifo_count);
  assign tag_idx      = ret ? outstanding_q - 2'd1 : outstanding_q;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    wr_beat   = 1'b0;
    issue     = 1'b0;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          wr_beat = 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      READ: begin
        // Only issue when a FIFO slot is guaranteed for the returning beat.
        if (credits_used < UW'(RSP_DEPTH)) begin
          issue = 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      beats_q       <= '0;
      outstanding_q <= 2'd0;
      tag_q         <= '0;
      sram_wen      <= 1'b0;
      sram_ren      <= 1'b0;
      sram_waddr    <= '0;
      sram_raddr    <= '0;
      sram_wdata    <= '0;
    end else begin
      state_q  <= state_d;
      sram_wen <= wr_beat;
      sram_ren <= issue;
      if (accept) begin
        addr_q  <= cmd_addr;
        beats_q <= cmd_len;
      end else if (wr_beat || issue) begin
        addr_q  <= addr_q + AW'(1);
        beats_q <= beats_q - LW'(1);
      end
      if (wr_beat) begin
        sram_waddr <= addr_q;
        sram_wdata <= wr_data;
      end
      if (issue) sram_raddr <= addr_q;
      case ({issue, ret})
        2'b10:   outstanding_q <= outstanding_q + 2'd1;
        2'b01:   outstanding_q <= outstanding_q - 2'd1;
        default: outstanding_q <= outstanding_q;
      endcase
      // In-order tag queue: oldest at bit 0; a new tag lands after the survivors.
      if (ret) tag_q <= {1'b0, tag_q[3:1]};
      if (issue) tag_q[tag_idx] <= last_beat;
    end
  end

  spram_rsp_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ret),
    .push_data ({tag_q[0], sram_rdata}),
    .pop       (rsp_valid && rsp_ready),
    .head      (fifo_head),
    .valid     (rsp_valid),
    .count     (fifo_count)
  );

  assign rsp_data = fifo_head[WIDTH-1:0];
  assign rsp_last = fifo_head[WIDTH];
  assign busy     = (state_q != IDLE) || (fifo_count != '0) || (outstanding_q != 2'd0);

endmodule

// File: tb/tb_spram_initiator.sv
// Scoreboard bench for spram_initiator with a behavioural one-cycle SRAM model.
module tb_spram_initiator;

  localparam int WIDTH     = 32;
  localparam int SIZE      = 2048;
  localparam int MAX_LEN   = 16;
  localparam int RSP_DEPTH = 4;
  localparam int AW        = 11;
  localparam int LW        = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [LW-1:0]    cmd_len;
  logic             wr_valid, wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rsp_valid, rsp_ready, rsp_last, busy;
  logic [WIDTH-1:0] rsp_data;
  logic             sram_wen, sram_ren, sram_ready;
  logic [AW-1:0]    sram_waddr, sram_raddr;
  logic [WIDTH-1:0] sram_wdata, sram_rdata;
  logic             model_ready, inject_ready;

  logic [WIDTH-1:0] sram_mem [SIZE];
  logic [WIDTH-1:0] ref_mem  [SIZE];

  logic [AW+WIDTH-1:0] exp_wr    [$];
  logic [AW-1:0]       exp_raddr [$];
  logic [WIDTH:0]      exp_rsp   [$];
  logic [AW+WIDTH-1:0] wr_e;
  logic [AW-1:0]       rd_e;
  logic [WIDTH:0]      rsp_e;

  int n_vec = 0;
  int n_err = 0;
  int ren_count = 0;

  always #5 clk = ~clk;

  spram_initiator #(
    .WIDTH(WIDTH), .SIZE(SIZE), .MAX_LEN(MAX_LEN), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy),
    .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_waddr(sram_waddr), .sram_raddr(sram_raddr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  // One-cycle SRAM: a read strobe seen at an edge returns data and ready the next cycle.
  initial for (int i = 0; i < SIZE; i++) sram_mem[i] = WIDTH'(i);
  always @(posedge clk) begin
    if (sram_wen) sram_mem[sram_waddr] <= sram_wdata;
    if (sram_ren) sram_rdata <= sram_mem[sram_raddr];
    model_ready <= sram_ren;
  end
  assign sram_ready = model_ready | inject_ready;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (sram_wen && sram_ren) checkOutput("wen_ren_overlap", 64'd1, 64'd0);
      if (sram_wen) begin
        if (exp_wr.size() == 0) checkOutput("unexpected_wen", 64'd1, 64'd0);
        else begin
          wr_e = exp_wr.pop_front();
          checkOutput("sram_waddr", 64'(sram_waddr), 64'(wr_e[AW+WIDTH-1:WIDTH]));
          checkOutput("sram_wdata", 64'(sram_wdata), 64'(wr_e[WIDTH-1:0]));
        end
      end
      if (sram_ren) begin
        ren_count++;
        if (exp_raddr.size() == 0) checkOutput("unexpected_ren", 64'd1, 64'd0);
        else begin
          rd_e = exp_raddr.pop_front();
          checkOutput("sram_raddr", 64'(sram_raddr), 64'(rd_e));
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) checkOutput("unexpected_rsp", 64'd1, 64'd0);
        else begin
          rsp_e = exp_rsp.pop_front();
          checkOutput("rsp_data", 64'(rsp_data), 64'(rsp_e[WIDTH-1:0]));
          checkOutput("rsp_last", 64'(rsp_last), 64'(rsp_e[WIDTH]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cmd_ready"},  64'(cmd_ready),  64'd1);
    checkOutput({tag, "_wr_ready"},   64'(wr_ready),   64'd0);
    checkOutput({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    checkOutput({tag, "_rsp_data"},   64'(rsp_data),   64'd0);
    checkOutput({tag, "_rsp_last"},   64'(rsp_last),   64'd0);
    checkOutput({tag, "_busy"},       64'(busy),       64'd0);
    checkOutput({tag, "_sram_wen"},   64'(sram_wen),   64'd0);
    checkOutput({tag, "_sram_ren"},   64'(sram_ren),   64'd0);
    checkOutput({tag, "_sram_waddr"}, 64'(sram_waddr), 64'd0);
    checkOutput({tag, "_sram_raddr"}, 64'(sram_raddr), 64'd0);
    checkOutput({tag, "_sram_wdata"}, 64'(sram_wdata), 64'd0);
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("cmd_timeout", 64'd1, 64'd0);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] data);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = data;
    @(negedge clk);
    while (!wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("wr_timeout", 64'd1, 64'd0);
    step();
    wr_valid = 1'b0;
  endtask

  // Queues the expected SRAM traffic and responses, then drives the command (and write beats).
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                               input logic [WIDTH-1:0] data0);
    for (int i = 0; i <= int'(len); i++) begin
      logic [AW-1:0] a;
      a = addr + AW'(i);
      if (wr) begin
        exp_wr.push_back({a, data0 + WIDTH'(i)});
        ref_mem[a] = data0 + WIDTH'(i);
      end else begin
        exp_raddr.push_back(a);
        exp_rsp.push_back({(i == int'(len)), ref_mem[a]});
      end
    end
    send_cmd(wr, addr, len);
    if (wr) for (int i = 0; i <= int'(len); i++) send_beat(data0 + WIDTH'(i));
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int n;
    for (int i = 0; i < SIZE; i++) ref_mem[i] = WIDTH'(i);
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b1; inject_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkReset("reset");

    // Single write: state change visible the cycle after accept, no strobe yet.
    step();
    exp_wr.push_back({11'h005, 32'hDEADBEEF});
    ref_mem[11'h005] = 32'hDEADBEEF;
    send_cmd(1'b1, 11'h005, 4'd0);
    #3;
    checkOutput("wr_ready_after_accept", 64'(wr_ready), 64'd1);
    checkOutput("no_strobe_after_accept", 64'(sram_wen | sram_ren), 64'd0);
    send_beat(32'hDEADBEEF);
    wait_idle(50);

    // Read burst of 4: first response 4 negedges after the accept edge.
    step();
    rsp_ready = 1'b1;
    base = ren_count;
    applyStimulus(1'b0, 11'h010, 4'd3, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    checkOutput("rsp_latency", 64'(n), 64'd4);
    wait_idle(100);
    checkOutput("ren_pulses_burst4", 64'(ren_count - base), 64'd4);

    // Address wrap at the top of the array.
    step();
    applyStimulus(1'b1, 11'h7FE, 4'd3, 32'hA0A0_0000);
    wait_idle(50);

    // Backpressure: only RSP_DEPTH reads may be in flight or queued.
    step();
    rsp_ready = 1'b0;
    base = ren_count;
    applyStimulus(1'b0, 11'h100, 4'd15, 32'h0);
    repeat (20) @(negedge clk);
    checkOutput("ren_stall_count", 64'(ren_count - base), 64'd4);
    checkOutput("rsp_held_valid", 64'(rsp_valid), 64'd1);
    checkOutput("busy_stalled", 64'(busy), 64'd1);
    step();
    rsp_ready = 1'b1;
    wait_idle(400);
    checkOutput("ren_total_burst16", 64'(ren_count - base), 64'd16);
    checkOutput("rsp_drained", 64'(exp_rsp.size()), 64'd0);

    // Back-to-back read then write with read data still queued.
    step();
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 11'h020, 4'd1, 32'h0);
    applyStimulus(1'b1, 11'h030, 4'd0, 32'h1234_5678);
    repeat (3) @(negedge clk);
    checkOutput("rsp_queued_b2b", 64'(rsp_valid), 64'd1);
    checkOutput("wr_done_b2b", 64'(exp_wr.size()), 64'd0);
    step();
    rsp_ready = 1'b1;
    wait_idle(100);
    checkOutput("rsp_drained_b2b", 64'(exp_rsp.size()), 64'd0);

    // Reset in the middle of a read burst, then a stray SRAM return.
    step();
    rsp_ready = 1'b0;
    base = ren_count;
    applyStimulus(1'b0, 11'h040, 4'd7, 32'h0);
    n = 0;
    while ((ren_count - base) < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ren_before_reset", 64'(ren_count - base), 64'd2);
    #1 rst = 1'b1;
    exp_raddr.delete();
    exp_rsp.delete();
    #2;
    checkReset("midreset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    inject_ready = 1'b1;
    step();
    inject_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("late_ready_no_rsp", 64'(rsp_valid), 64'd0);
    end
    checkReset("after_late_ready");
    checkOutput("wr_queue_empty", 64'(exp_wr.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
